// File: rtl/jk_register_bank.sv
// Bank of WIDTH JK flip-flops with JK, parallel-load, up/down count and shift modes.
// Each mode is mapped onto per-bit J/K controls so every bit stays a plain JK cell.
module jk_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_BIT;
    else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end
endmodule

module jk_register_bank #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic             Dir,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] D,
  input  logic             Sin,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             Sout,
  output logic             Tc,
  output logic             Toggled
);
  typedef enum logic [1:0] {
    M_JK    = 2'b00,
    M_LOAD  = 2'b01,
    M_COUNT = 2'b10,
    M_SHIFT = 2'b11
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] lo_ones, lo_zero;
  logic [WIDTH-1:0] j_eff, k_eff, chg;
  logic [WIDTH-1:0] shift_src;

  assign mode = mode_e'(Mode);

  // Toggle-chain enables: bit i flips when every lower bit is 1 (up) or 0 (down).
  assign lo_ones[0]   = 1'b1;
  assign lo_zero[0]   = 1'b1;
  assign shift_src[0] = Sin;
  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_chain
      assign lo_ones[gi]   = lo_ones[gi-1] & Q[gi-1];
      assign lo_zero[gi]   = lo_zero[gi-1] & ~Q[gi-1];
      assign shift_src[gi] = Q[gi-1];
    end
  endgenerate

  always_comb begin
    j_eff = '0;
    k_eff = '0;
    if (En) begin
      case (mode)
        M_JK:    begin j_eff = J;         k_eff = K;          end
        M_LOAD:  begin j_eff = D;         k_eff = ~D;         end
        M_COUNT: begin
          j_eff = Dir ? lo_ones : lo_zero;
          k_eff = Dir ? lo_ones : lo_zero;
        end
        M_SHIFT: begin j_eff = shift_src; k_eff = ~shift_src; end
        default: begin j_eff = '0;        k_eff = '0;         end
      endcase
    end
  end

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell #(.RST_BIT(RESET_VALUE[gi])) u_cell (
        .clk  (Clk),
        .rst_n(Rst_n),
        .j    (j_eff[gi]),
        .k    (k_eff[gi]),
        .q    (Q[gi])
      );
    end
  endgenerate

  // A bit changes when it is set while low or cleared while high; toggle covers both.
  assign chg = (j_eff & ~Q) | (k_eff & Q);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)  Toggled <= 1'b0;
    else if (En) Toggled <= |chg;
  end

  assign Qbar = ~Q;
  assign Sout = Q[WIDTH-1];
  assign Tc   = En & (mode == M_COUNT) & ((Dir & (&Q)) | (~Dir & ~(|Q)));
endmodule

// File: tb/tb_jk_register_bank.sv
// Directed bench for jk_register_bank: an 8-bit reset-to-0 instance and a 4-bit reset-to-0xA instance.
module tb_jk_register_bank;
  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       En;
  logic [1:0] Mode;
  logic       Dir;
  logic [7:0] J, K, D;
  logic       Sin;
  logic [7:0] Q, Qbar;
  logic       Sout, Tc, Toggled;

  logic       En4;
  logic [1:0] Mode4;
  logic       Dir4;
  logic [3:0] J4, K4, D4;
  logic       Sin4;
  logic [3:0] Q4, Qbar4;
  logic       Sout4, Tc4, Toggled4;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] JK = 2'b00, LOAD = 2'b01, COUNT = 2'b10, SHIFT = 2'b11;

  always #5 Clk = ~Clk;

  jk_register_bank #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .Mode(Mode), .Dir(Dir), .J(J), .K(K), .D(D),
    .Sin(Sin), .Q(Q), .Qbar(Qbar), .Sout(Sout), .Tc(Tc), .Toggled(Toggled)
  );

  jk_register_bank #(.WIDTH(4), .RESET_VALUE(4'hA)) dut4 (
    .Clk(Clk), .Rst_n(Rst_n), .En(En4), .Mode(Mode4), .Dir(Dir4), .J(J4), .K(K4), .D(D4),
    .Sin(Sin4), .Q(Q4), .Qbar(Qbar4), .Sout(Sout4), .Tc(Tc4), .Toggled(Toggled4)
  );

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    En = 1'b1; Mode = LOAD; D = v;
    step();
  endtask

  task automatic test_reset();
    step();
    checks++;
    if (Q !== 8'h00 || Toggled !== 1'b0) begin
      errors++; $display("FAIL reset_init: Q=%h Toggled=%b, want Q=00 Toggled=0", Q, Toggled);
    end
    Rst_n = 1'b1;
    do_load(8'hA5);
    checks++;
    if (Q !== 8'hA5 || Toggled !== 1'b1) begin
      errors++; $display("FAIL reset_pre: Q=%h Toggled=%b, want Q=a5 Toggled=1", Q, Toggled);
    end
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if (Q !== 8'h00 || Qbar !== 8'hFF || Toggled !== 1'b0) begin
      errors++; $display("FAIL reset_async: Q=%h Qbar=%h Toggled=%b, want 00 ff 0", Q, Qbar, Toggled);
    end
    #1 Rst_n = 1'b1;
  endtask

  task automatic test_jk();
    do_load(8'h0F);
    Mode = JK; J = 8'h33; K = 8'h55;
    step();
    checks++;
    if (Q !== 8'h3A || Qbar !== 8'hC5 || Toggled !== 1'b1) begin
      errors++; $display("FAIL jk_edge1: Q=%h Qbar=%h Toggled=%b, want 3a c5 1", Q, Qbar, Toggled);
    end
    step();
    checks++;
    if (Q !== 8'h2B || Toggled !== 1'b1) begin
      errors++; $display("FAIL jk_edge2: Q=%h Toggled=%b, want 2b 1", Q, Toggled);
    end
  endtask

  task automatic test_count();
    logic [7:0] exp_q [4];
    logic       exp_tc[4];
    logic       dirs  [4];
    exp_q = '{8'hFF, 8'h00, 8'hFF, 8'hFE};
    exp_tc = '{1'b1, 1'b0, 1'b0, 1'b0};
    dirs = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_load(8'hFE);
    Mode = COUNT; Dir = 1'b1;
    #1;
    checks++;
    if (Tc !== 1'b0) begin
      errors++; $display("FAIL count_tc_fe: Tc=%b want 0", Tc);
    end
    for (int i = 0; i < 4; i++) begin
      Dir = dirs[i];
      step();
      checks++;
      if (Q !== exp_q[i] || Tc !== exp_tc[i]) begin
        errors++; $display("FAIL count_%0d: Q=%h Tc=%b, want %h %b", i, Q, Tc, exp_q[i], exp_tc[i]);
      end
      if (i == 1) begin
        Dir = 1'b0;
        #1;
        checks++;
        if (Tc !== 1'b1) begin
          errors++; $display("FAIL count_tc_down0: Tc=%b want 1", Tc);
        end
      end
    end
    Mode = JK;
    #1;
    checks++;
    if (Tc !== 1'b0) begin
      errors++; $display("FAIL tc_other_mode: Tc=%b want 0", Tc);
    end
  endtask

  task automatic test_shift();
    logic       sins [3];
    logic [7:0] exp_q[3];
    logic       exp_so[3];
    sins = '{1'b1, 1'b0, 1'b1};
    exp_q = '{8'h03, 8'h06, 8'h0D};
    exp_so = '{1'b1, 1'b0, 1'b0};
    do_load(8'h81);
    Mode = SHIFT;
    for (int i = 0; i < 3; i++) begin
      Sin = sins[i];
      #1;
      checks++;
      if (Sout !== exp_so[i]) begin
        errors++; $display("FAIL shift_sout_%0d: Sout=%b want %b", i, Sout, exp_so[i]);
      end
      step();
      checks++;
      if (Q !== exp_q[i]) begin
        errors++; $display("FAIL shift_q_%0d: Q=%h want %h", i, Q, exp_q[i]);
      end
    end
  endtask

  task automatic test_hold();
    do_load(8'h5C);
    En = 1'b0; Mode = COUNT; Dir = 1'b1; J = 8'hFF; K = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (Q !== 8'h5C || Toggled !== 1'b1 || Tc !== 1'b0) begin
        errors++; $display("FAIL hold_%0d: Q=%h Toggled=%b Tc=%b, want 5c 1 0", i, Q, Toggled, Tc);
      end
    end
    En = 1'b1; Mode = JK; J = 8'h00; K = 8'h00;
    step();
    checks++;
    if (Q !== 8'h5C || Toggled !== 1'b0) begin
      errors++; $display("FAIL jk_hold: Q=%h Toggled=%b, want 5c 0", Q, Toggled);
    end
  endtask

  task automatic test_reset_mid();
    do_load(8'h40);
    Mode = COUNT; Dir = 1'b1;
    step();
    checks++;
    if (Q !== 8'h41) begin
      errors++; $display("FAIL mid_count: Q=%h want 41", Q);
    end
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if (Q !== 8'h00 || Toggled !== 1'b0) begin
      errors++; $display("FAIL mid_reset: Q=%h Toggled=%b, want 00 0", Q, Toggled);
    end
    #1 Rst_n = 1'b1;
    step();
    checks++;
    if (Q !== 8'h01 || Toggled !== 1'b1) begin
      errors++; $display("FAIL mid_resume: Q=%h Toggled=%b, want 01 1", Q, Toggled);
    end
  endtask

  task automatic test_width4();
    logic [3:0] exp_q[6];
    exp_q = '{4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
    checks++;
    if (Q4 !== 4'hA || Qbar4 !== 4'h5 || Sout4 !== 1'b1) begin
      errors++; $display("FAIL w4_reset: Q=%h Qbar=%h Sout=%b, want a 5 1", Q4, Qbar4, Sout4);
    end
    En4 = 1'b1; Mode4 = COUNT; Dir4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (Tc4 !== (i == 5)) begin
        errors++; $display("FAIL w4_tc_%0d: Tc=%b want %b", i, Tc4, (i == 5));
      end
      step();
      checks++;
      if (Q4 !== exp_q[i]) begin
        errors++; $display("FAIL w4_count_%0d: Q=%h want %h", i, Q4, exp_q[i]);
      end
    end
  endtask

  initial begin
    Rst_n = 1'b0; En = 1'b1; Mode = JK; Dir = 1'b1; J = '0; K = '0; D = '0; Sin = 1'b0;
    En4 = 1'b0; Mode4 = JK; Dir4 = 1'b1; J4 = '0; K4 = '0; D4 = '0; Sin4 = 1'b0;
    #2;
    test_reset();
    test_width4();
    test_jk();
    test_count();
    test_shift();
    test_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
